// File: rtl/week_day_selector_if.sv
// Pin bundle between the day selector and its driver: raw keys and auto enable in,
// day code plus sequencer refresh handshake out.
interface week_day_selector_if;
  logic       key_inc_n;
  logic       key_dec_n;
  logic       en_auto;
  logic [2:0] week_state;
  logic       refresh_n;
  logic       busy;

  modport master (
    output key_inc_n, key_dec_n, en_auto,
    input  week_state, refresh_n, busy
  );

  modport slave (
    input  key_inc_n, key_dec_n, en_auto,
    output week_state, refresh_n, busy
  );
endinterface

// File: rtl/week_day_selector.sv
// Day-of-week code (0..6) stepped by debounced INC/DEC keys or an auto-advance timer;
// every change restarts the LCD sequencer through an active-low refresh pulse.
module week_day_selector #(
  parameter int unsigned DB_CYCLES   = 1000000,
  parameter int unsigned REFRESH_LEN = 16,
  parameter int unsigned AUTO_PERIOD = 50000000
) (
  input  logic                clk,
  input  logic                rst,
  week_day_selector_if.slave  bus
);

  localparam int unsigned NKEY   = 2;
  localparam int unsigned DB_W   = $clog2(DB_CYCLES);
  localparam int unsigned AUTO_W = $clog2(AUTO_PERIOD);
  localparam int unsigned RF_W   = $clog2(REFRESH_LEN + 1);
  localparam int unsigned DAY_W  = 3;

  typedef enum logic [1:0] {
    STARTUP = 2'd0,
    IDLE    = 2'd1,
    PULSE   = 2'd2
  } state_t;

  // Key index 0 is INC, index 1 is DEC.
  logic [NKEY-1:0] raw_n_c;
  logic [NKEY-1:0] sync1;
  logic [NKEY-1:0] sync2;
  logic [NKEY-1:0] stable;
  logic [NKEY-1:0] stable_d;
  logic [NKEY-1:0] press;
  logic [DB_W-1:0] db_cnt [NKEY];

  logic [AUTO_W-1:0] auto_cnt;
  logic              tick_c;

  logic [DAY_W-1:0] day;
  logic [DAY_W-1:0] day_nxt_c;
  logic             day_chg_c;
  logic             up_c;
  logic             dn_c;

  state_t          state;
  state_t          state_nxt_c;
  logic [RF_W-1:0] rf_cnt;
  logic [RF_W-1:0] rf_cnt_nxt_c;
  logic            refresh_n;
  logic            busy;

  assign raw_n_c = {bus.key_dec_n, bus.key_inc_n};

  // Two-flop synchronizers, stable-level debounce and falling-edge press events.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '1;
      sync2    <= '1;
      stable   <= '1;
      stable_d <= '1;
      press    <= '0;
      for (int k = 0; k < int'(NKEY); k++) db_cnt[k] <= '0;
    end else begin
      sync1    <= raw_n_c;
      sync2    <= sync1;
      stable_d <= stable;
      press    <= stable_d & ~stable;
      for (int k = 0; k < int'(NKEY); k++) begin
        if (sync2[k] == stable[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DB_W'(DB_CYCLES - 1)) begin
          stable[k] <= sync2[k];
          db_cnt[k] <= '0;
        end else begin
          db_cnt[k] <= db_cnt[k] + DB_W'(1);
        end
      end
    end
  end

  // Auto-advance: tick on the wrap cycle, counter parked at 0 while disabled.
  assign tick_c = bus.en_auto && (auto_cnt == AUTO_W'(AUTO_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (rst || !bus.en_auto) auto_cnt <= '0;
    else if (tick_c)         auto_cnt <= '0;
    else                     auto_cnt <= auto_cnt + AUTO_W'(1);
  end

  assign up_c = press[0] | tick_c;
  assign dn_c = press[1];

  // Next day value; an illegal 7 is forced back to 0 and treated as a change.
  always_comb begin
    day_nxt_c = day;
    day_chg_c = 1'b0;
    if (day == DAY_W'(7)) begin
      day_nxt_c = '0;
      day_chg_c = 1'b1;
    end else if (up_c && !dn_c) begin
      day_nxt_c = (day == DAY_W'(6)) ? '0 : day + DAY_W'(1);
      day_chg_c = 1'b1;
    end else if (dn_c && !up_c) begin
      day_nxt_c = (day == '0) ? DAY_W'(6) : day - DAY_W'(1);
      day_chg_c = 1'b1;
    end
  end

  // Refresh FSM; a change during the pulse restarts the count so the final day is rendered.
  always_comb begin
    state_nxt_c  = state;
    rf_cnt_nxt_c = rf_cnt;
    case (state)
      STARTUP: begin
        state_nxt_c  = PULSE;
        rf_cnt_nxt_c = '0;
      end
      IDLE: begin
        if (day_chg_c) begin
          state_nxt_c  = PULSE;
          rf_cnt_nxt_c = '0;
        end
      end
      PULSE: begin
        if (day_chg_c) begin
          rf_cnt_nxt_c = '0;
        end else if (rf_cnt == RF_W'(REFRESH_LEN - 1)) begin
          state_nxt_c  = IDLE;
          rf_cnt_nxt_c = '0;
        end else begin
          rf_cnt_nxt_c = rf_cnt + RF_W'(1);
        end
      end
      default: begin
        state_nxt_c  = STARTUP;
        rf_cnt_nxt_c = '0;
      end
    endcase
  end

  // Outputs follow the next state so the new day and refresh_n=0 appear on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= STARTUP;
      rf_cnt    <= '0;
      day       <= '0;
      refresh_n <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt_c;
      rf_cnt    <= rf_cnt_nxt_c;
      day       <= day_nxt_c;
      refresh_n <= (state_nxt_c != PULSE);
      busy      <= (state_nxt_c == PULSE);
    end
  end

  assign bus.week_state = day;
  assign bus.refresh_n  = refresh_n;
  assign bus.busy       = busy;

endmodule
